// File: rtl/fractal_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fractal_stream_pkg
// Description : Shared types and helpers for the fractal pixel stream sink:
//               RGB pixel struct, FIFO beat struct, sink state enum and the
//               iteration-count to colour mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package fractal_stream_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // One buffered output beat: colour plus the two AXI4-Stream sideband bits.
    typedef struct packed {
        rgb_t rgb;
        logic tuser;
        logic tlast;
    } pix_beat_t;

    localparam int c_BEAT_W = $bits(pix_beat_t);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        DROP = 2'd2
    } state_t;

    // Points that never escaped render black; everything else gets a cheap
    // palette derived directly from the iteration bits.
    function automatic rgb_t colour_map(input logic [7:0] iter, input logic [7:0] max_iter);
        rgb_t c;
        if (iter == max_iter) begin
            c = '0;
        end else begin
            c.r = iter;
            c.g = {iter[5:0], 2'b00};
            c.b = ~iter;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fractal_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fractal_stream_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on o_rd_data whenever o_empty is low; o_rd_data is
//               forced to zero while empty.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_wr_en/i_wr_data - write request; refused while full
//               o_full            - full flag (pre-read occupancy)
//               i_rd_en           - pop head entry; ignored while empty
//               o_rd_data/o_empty - head entry and empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_stream_fifo
    import fractal_stream_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = c_BEAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW:0] c_CNT_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_full  = (r_count == c_CNT_FULL);
    assign o_empty = (r_count == '0);

    // Both qualifiers look at the occupancy before this cycle's pop, so a
    // write into a full FIFO is refused even if a read frees a slot.
    assign w_wr_ok = i_wr_en && !o_full;
    assign w_rd_ok = i_rd_en && !o_empty;

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fractal_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : fractal_stream_sink
// Description : Consumer end of the fractal pixel stream. Checks frame
//               structure against the latched width/height, colour-maps each
//               iteration count, buffers pixels in a FWFT FIFO and re-emits
//               them as an AXI4-Stream master with backpressure.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               width, height         - frame size, latched on frame start
//               s_data/s_frame_start/s_line_end/s_valid - unstallable input
//               m_tdata/m_tuser/m_tlast/m_tvalid/m_tready - stream output
//               overflow, framing_error - sticky error flags
//               err_clear             - clears both sticky flags
//               frame_count           - complete frames written to the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_stream_sink
    import fractal_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int MAX_ITER   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [7:0]  s_data,
    input  logic        s_frame_start,
    input  logic        s_line_end,
    input  logic        s_valid,
    output logic [23:0] m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        overflow,
    output logic        framing_error,
    input  logic        err_clear,
    output logic [31:0] frame_count
);

    localparam logic [7:0] c_MAX_ITER = 8'(MAX_ITER);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_width;
    logic [15:0] r_height;

    logic        w_at_origin;
    logic        w_latch;
    logic        w_accept;
    logic        w_ferr;
    logic        w_ovf_evt;
    logic [15:0] w_wid;
    logic [15:0] w_hgt;
    logic [15:0] w_pos_x;
    logic [15:0] w_pos_y;
    logic        w_x_end;
    logic        w_y_end;
    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic        w_frame_done;

    pix_beat_t   r_pipe_beat;
    logic        r_pipe_valid;
    logic        r_pipe_done;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    pix_beat_t   w_fifo_out;

    logic        r_overflow;
    logic        r_framing_error;
    logic [31:0] r_frame_count;

    // ------------------------------------------------------------------
    // Beat classification and next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_accept     = 1'b0;
        w_ferr       = 1'b0;
        w_at_origin  = (r_x == 16'd0) && (r_y == 16'd0);

        if (s_valid) begin
            case (r_state)
                RUN: begin
                    if (s_frame_start) begin
                        // An early frame start is flagged but still honoured
                        // as the beginning of a new frame.
                        w_ferr  = !w_at_origin;
                        w_latch = 1'b1;
                    end else if (w_at_origin ||
                                 (s_line_end != (r_x == r_width - 16'd1))) begin
                        w_ferr       = 1'b1;
                        w_next_state = DROP;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
                default: begin
                    w_latch = s_frame_start;
                end
            endcase
        end

        // A frame-start beat is positioned at the origin of the new frame
        // and measured against the freshly sampled geometry.
        w_wid   = w_latch ? width  : r_width;
        w_hgt   = w_latch ? height : r_height;
        w_pos_x = w_latch ? 16'd0  : r_x;
        w_pos_y = w_latch ? 16'd0  : r_y;

        if (w_latch) begin
            if ((width == 16'd0) || (height == 16'd0)) begin
                w_next_state = SYNC;
            end else begin
                w_accept     = 1'b1;
                w_next_state = RUN;
            end
        end

        // A refused FIFO write also kills the beat being evaluated right now;
        // the partial frame is abandoned until the next frame start.
        w_ovf_evt = r_pipe_valid && w_fifo_full;
        if (w_ovf_evt) begin
            w_accept     = 1'b0;
            w_next_state = DROP;
        end

        w_x_end      = (w_pos_x == w_wid - 16'd1);
        w_y_end      = (w_pos_y == w_hgt - 16'd1);
        w_x_nxt      = w_x_end ? 16'd0 : w_pos_x + 16'd1;
        w_y_nxt      = w_x_end ? (w_y_end ? 16'd0 : w_pos_y + 16'd1) : w_pos_y;
        w_frame_done = w_accept && w_x_end && w_y_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Position counters, colour stage, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x             <= 16'd0;
            r_y             <= 16'd0;
            r_width         <= 16'd0;
            r_height        <= 16'd0;
            r_pipe_valid    <= 1'b0;
            r_pipe_done     <= 1'b0;
            r_pipe_beat     <= '0;
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
            r_frame_count   <= 32'd0;
        end else begin
            if (w_latch) begin
                r_width  <= width;
                r_height <= height;
            end
            if (w_accept) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end

            r_pipe_valid      <= w_accept;
            r_pipe_done       <= w_frame_done;
            r_pipe_beat.rgb   <= colour_map(s_data, c_MAX_ITER);
            r_pipe_beat.tuser <= s_frame_start;
            r_pipe_beat.tlast <= s_line_end;

            // A new error in the same cycle as err_clear keeps the flag set.
            r_overflow      <= w_ovf_evt | (r_overflow      & ~err_clear);
            r_framing_error <= w_ferr    | (r_framing_error & ~err_clear);

            // Counted when the frame's final pixel actually lands in the FIFO.
            if (r_pipe_valid && !w_fifo_full && r_pipe_done) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

    fractal_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (r_pipe_valid),
        .i_wr_data (r_pipe_beat),
        .o_full    (w_fifo_full),
        .i_rd_en   (m_tready),
        .o_rd_data (w_fifo_out),
        .o_empty   (w_fifo_empty)
    );

    assign m_tvalid      = !w_fifo_empty;
    assign m_tdata       = w_fifo_out.rgb;
    assign m_tuser       = w_fifo_out.tuser;
    assign m_tlast       = w_fifo_out.tlast;
    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;
    assign frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_fractal_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fractal_stream_sink
// Description : Self-checking bench for fractal_stream_sink. Expected output
//               beats are queued from the frame rules and colour formula and
//               compared against every AXI4-Stream transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fractal_stream_sink;

    localparam int c_DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [15:0] width;
    logic [15:0] height;
    logic [7:0]  s_data;
    logic        s_frame_start;
    logic        s_line_end;
    logic        s_valid;
    logic [23:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        overflow;
    logic        framing_error;
    logic        err_clear;
    logic [31:0] frame_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [25:0] exp_q[$];
    int          exp_fc  = 0;
    logic        exp_ferr = 1'b0;
    bit          rand_ready = 1'b0;

    fractal_stream_sink #(
        .FIFO_DEPTH (c_DEPTH),
        .MAX_ITER   (255)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .width         (width),
        .height        (height),
        .s_data        (s_data),
        .s_frame_start (s_frame_start),
        .s_line_end    (s_line_end),
        .s_valid       (s_valid),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .overflow      (overflow),
        .framing_error (framing_error),
        .err_clear     (err_clear),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference colour formula in plain arithmetic.
    function automatic logic [23:0] cmap(input int it);
        int r, g, b;
        if (it == 255) return 24'h000000;
        r = it;
        g = (it * 4) % 256;
        b = 255 - it;
        return 24'((r << 16) | (g << 8) | b);
    endfunction

    // Output monitor: every transfer must match the head of the queue and a
    // stalled beat must stay put.
    logic        prev_stall = 1'b0;
    logic [25:0] prev_beat  = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                check("beat_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(exp_q.pop_front()));
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tdata, m_tuser, m_tlast};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input logic [7:0] d, input logic fs, input logic le);
        s_valid       = 1'b1;
        s_data        = d;
        s_frame_start = fs;
        s_line_end    = le;
        step();
        s_valid       = 1'b0;
        s_data        = 8'($urandom);
        s_frame_start = 1'($urandom);
        s_line_end    = 1'($urandom);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || m_tvalid) && i < 400) begin
            step();
            i++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(m_tvalid), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_fc   = 0;
        exp_ferr = 1'b0;
    endtask

    // Send a w x h frame. corrupt >= 0 flips line_end at that beat index:
    // beats before it are output, it and the rest of the frame are lost.
    task automatic send_frame(input int w, input int h, input int corrupt, input bit gaps);
        int  it, k;
        logic fs, le;
        width  = 16'(w);
        height = 16'(h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                k  = y * w + x;
                it = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
                fs = (k == 0);
                le = (x == w - 1);
                if (k == corrupt) le = !le;
                if (corrupt < 0 || k < corrupt) exp_q.push_back({cmap(it), fs, le});
                if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                drive(8'(it), fs, le);
                if (k == 0) begin
                    width  = 16'($urandom);
                    height = 16'($urandom);
                end
            end
        end
        if (corrupt < 0) exp_fc++;
        else exp_ferr = 1'b1;
    endtask

    initial begin
        int w, h, n, c;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_frame_start = 1'b0;
        s_line_end = 1'b0; m_tready = 1'b0; err_clear = 1'b0;
        width = 16'd0; height = 16'd0;

        // Reset state
        repeat (3) step();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_fcount", frame_count, 32'd0);
        reset = 1'b0;

        // Nominal 4x2 frame, iterations 0..7, with input-to-valid latency
        m_tready = 1'b1;
        width = 16'd4; height = 16'd2;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({cmap(k), 1'(k == 0), 1'((k % 4) == 3)});
            drive(8'(k), 1'(k == 0), 1'((k % 4) == 3));
            if (k == 0) check("latency_1cyc", 32'(m_tvalid), 32'd0);
            if (k == 1) check("latency_2cyc", 32'(m_tvalid), 32'd1);
        end
        exp_fc = 1;
        wait_drain();
        check("nom_fcount", frame_count, 32'(exp_fc));
        check("nom_ferr", 32'(framing_error), 32'd0);
        check("nom_overflow", 32'(overflow), 32'd0);

        // Colour map corner values
        width = 16'd3; height = 16'd1;
        exp_q.push_back({24'h1040EF, 1'b1, 1'b0});
        exp_q.push_back({24'h000000, 1'b0, 1'b0});
        exp_q.push_back({24'h3FFCC0, 1'b0, 1'b1});
        drive(8'h10, 1'b1, 1'b0);
        drive(8'hFF, 1'b0, 1'b0);
        drive(8'h3F, 1'b0, 1'b1);
        exp_fc = 2;
        wait_drain();
        check("cmap_fcount", frame_count, 32'(exp_fc));

        // Joining mid-frame: beats before the first frame start are ignored
        do_reset();
        width = 16'd4; height = 16'd2;
        for (int k = 0; k < 3; k++) drive(8'($urandom), 1'b0, 1'($urandom));
        send_frame(4, 2, -1, 1'b0);
        wait_drain();
        check("sync_fcount", frame_count, 32'(exp_fc));
        check("sync_ferr", 32'(framing_error), 32'd0);

        // Backpressure overflow: 4x8 frame into a 16-entry FIFO
        do_reset();
        m_tready = 1'b0;
        width = 16'd4; height = 16'd8;
        for (int k = 0; k < 32; k++) begin
            if (k < 16) exp_q.push_back({cmap(k + 40), 1'(k == 0), 1'((k % 4) == 3)});
            drive(8'(k + 40), 1'(k == 0), 1'((k % 4) == 3));
            if (k == 16) check("ovf_before", 32'(overflow), 32'd0);
            if (k == 17) check("ovf_after", 32'(overflow), 32'd1);
        end
        idle(3);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_buffered", 32'(m_tvalid), 32'd1);
        check("ovf_fcount", frame_count, 32'd0);
        m_tready = 1'b1;
        wait_drain();
        send_frame(4, 8, -1, 1'b0);
        wait_drain();
        check("ovf_next_fcount", frame_count, 32'd1);

        // Framing error: early line_end at x=2
        do_reset();
        send_frame(4, 2, 2, 1'b0);
        idle(2);
        wait_drain();
        check("ferr_set", 32'(framing_error), 32'd1);
        check("ferr_fcount", frame_count, 32'd0);
        send_frame(4, 2, -1, 1'b0);
        wait_drain();
        check("ferr_resync_fcount", frame_count, 32'(exp_fc));
        check("ferr_still", 32'(framing_error), 32'd1);
        // missing frame start at the origin together with err_clear
        err_clear = 1'b1;
        drive(8'h55, 1'b0, 1'b0);
        err_clear = 1'b0;
        check("ferr_err_wins", 32'(framing_error), 32'd1);
        idle(3);
        wait_drain();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        exp_ferr = 1'b0;
        check("ferr_cleared", 32'(framing_error), 32'd0);
        check("ovf_clear_state", 32'(overflow), 32'd0);

        // Randomized frames, gaps and backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
            n = w * h;
            c = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            send_frame(w, h, c, 1'b1);
            idle($urandom_range(0, 2));
            wait_drain();
        end
        rand_ready = 1'b0;
        m_tready = 1'b1;
        check("rand_fcount", frame_count, 32'(exp_fc));
        check("rand_ferr", 32'(framing_error), 32'(exp_ferr));
        check("rand_overflow", 32'(overflow), 32'd0);

        // Reset with 5 pixels buffered
        m_tready = 1'b0;
        width = 16'd4; height = 16'd2;
        for (int k = 0; k < 5; k++) drive(8'(k + 100), 1'(k == 0), 1'((k % 4) == 3));
        idle(3);
        check("pre_reset_buffered", 32'(m_tvalid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_fc = 0;
        check("post_reset_tvalid", 32'(m_tvalid), 32'd0);
        check("post_reset_ovf", 32'(overflow), 32'd0);
        check("post_reset_ferr", 32'(framing_error), 32'd0);
        check("post_reset_fcount", frame_count, 32'd0);
        m_tready = 1'b1;
        send_frame(4, 2, -1, 1'b0);
        wait_drain();
        check("post_reset_frame", frame_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
